// File: rtl/race_pkg.sv
// Shared encodings for the LED race game-flow logic: controller states and player ids.
package race_pkg;

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        RACING   = 2'd1,
        FINISHED = 2'd2
    } race_state_e;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } player_id_e;

endpackage

// File: rtl/finish_hold_timer.sv
// Down-counter measuring time spent on the end screen; tc fires on the last hold cycle.
// Used by race_finish_controller only when FINISH_TIMEOUT_EN is defined.
module finish_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Loaded with HOLD_CYCLES-1 so tc lands on the HOLD_CYCLES-th enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= CNT_W'(HOLD_CYCLES - 1);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/race_finish_controller.sv
// Menu/race/finish lifecycle controller for the LED race; latches the first finisher.
// Optional macro FINISH_TIMEOUT_EN: automatic return to menu after HOLD_CYCLES in FINISHED.
module race_finish_controller
    import race_pkg::*;
#(
    parameter int MAX_POS     = 109,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_pulse,
    input  logic [$clog2(MAX_POS)-1:0] green_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] red_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] blue_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] yellow_cur_pos,
    output logic                       is_in_menu,
    output logic                       game_over,
    output logic [1:0]                 winner,
    output logic                       winner_valid,
    output logic                       players_reset
);

    localparam int                 POS_W      = $clog2(MAX_POS);
    localparam logic [POS_W-1:0]   FINISH_POS = POS_W'(MAX_POS - 1);

    race_state_e state, state_nxt;
    logic        armed;
    logic        hold_tc;
    logic [3:0]  finished;
    logic [1:0]  winner_nxt;
    logic        winner_valid_nxt;
    logic        players_reset_nxt;

`ifdef FINISH_TIMEOUT_EN
    finish_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state != FINISHED),
        .en   (state == FINISHED),
        .tc   (hold_tc)
    );
`else
    // Timeout disabled: the comparison is constant false, so no counter exists.
    assign hold_tc = (HOLD_CYCLES < 0);
`endif

    assign finished = {yellow_cur_pos >= FINISH_POS,
                       blue_cur_pos   >= FINISH_POS,
                       red_cur_pos    >= FINISH_POS,
                       green_cur_pos  >= FINISH_POS};

    always_comb begin
        state_nxt         = state;
        winner_nxt        = winner;
        winner_valid_nxt  = winner_valid;
        players_reset_nxt = 1'b0;
        case (state)
            MENU: begin
                if (start_pulse) begin
                    state_nxt         = RACING;
                    players_reset_nxt = 1'b1;
                    winner_valid_nxt  = 1'b0;
                end
            end
            RACING: begin
                // Unarmed first cycle ignores stale positions from the previous race.
                if (armed && (finished != 4'b0000)) begin
                    state_nxt        = FINISHED;
                    winner_valid_nxt = 1'b1;
                    if (finished[0])      winner_nxt = GREEN;
                    else if (finished[1]) winner_nxt = RED;
                    else if (finished[2]) winner_nxt = BLUE;
                    else                  winner_nxt = YELLOW;
                end
            end
            FINISHED: begin
                if (start_pulse || hold_tc) begin
                    state_nxt = MENU;
                end
            end
            default: state_nxt = MENU;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MENU;
            armed         <= 1'b0;
            is_in_menu    <= 1'b1;
            game_over     <= 1'b0;
            winner        <= 2'd0;
            winner_valid  <= 1'b0;
            players_reset <= 1'b0;
        end else begin
            state         <= state_nxt;
            armed         <= (state == RACING);
            is_in_menu    <= (state_nxt == MENU);
            game_over     <= (state_nxt == FINISHED);
            winner        <= winner_nxt;
            winner_valid  <= winner_valid_nxt;
            players_reset <= players_reset_nxt;
        end
    end

endmodule

// File: tb/tb_race_finish_controller.sv
// Directed bench for race_finish_controller; covers the FINISH_TIMEOUT_EN build when defined.
module tb_race_finish_controller;

    localparam int MAX_POS     = 109;
    localparam int HOLD_CYCLES = 4;

    logic       clk;
    logic       rst;
    logic       start_pulse;
    logic [6:0] green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos;
    logic       is_in_menu, game_over, winner_valid, players_reset;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    race_finish_controller #(
        .MAX_POS    (MAX_POS),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_pulse   (start_pulse),
        .green_cur_pos (green_cur_pos),
        .red_cur_pos   (red_cur_pos),
        .blue_cur_pos  (blue_cur_pos),
        .yellow_cur_pos(yellow_cur_pos),
        .is_in_menu    (is_in_menu),
        .game_over     (game_over),
        .winner        (winner),
        .winner_valid  (winner_valid),
        .players_reset (players_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [6:0] g, input logic [6:0] r, input logic [6:0] b, input logic [6:0] y);
        green_cur_pos  = g;
        red_cur_pos    = r;
        blue_cur_pos   = b;
        yellow_cur_pos = y;
    endtask

    task automatic pulse_start();
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start_pulse = 1'b0;
        set_pos(7'd108, 7'd108, 7'd108, 7'd108);
        step();
        step();
        check("rst_menu",    is_in_menu,    1);
        check("rst_over",    game_over,     0);
        check("rst_valid",   winner_valid,  0);
        check("rst_winner",  winner,        0);
        check("rst_preset",  players_reset, 0);
        rst = 1'b0;

        // Finished-looking positions must not matter while in the menu.
        for (int i = 0; i < 3; i++) step();
        check("idle_menu", is_in_menu, 1);
        check("idle_over", game_over,  0);

        pulse_start();
        check("start_menu",   is_in_menu,    0);
        check("start_preset", players_reset, 1);
        check("start_over",   game_over,     0);
        set_pos(7'd0, 7'd0, 7'd0, 7'd0);
        step();
        check("masked_over",   game_over,     0);
        check("preset_once",   players_reset, 0);
        check("masked_menu",   is_in_menu,    0);
        for (int i = 0; i < 3; i++) step();
        check("racing_over", game_over, 0);

        red_cur_pos = 7'd107;
        step();
        check("red107_over", game_over, 0);
        red_cur_pos = 7'd108;
        step();
        check("red_over",   game_over,    1);
        check("red_winner", winner,       1);
        check("red_valid",  winner_valid, 1);
        check("red_menu",   is_in_menu,   0);
        green_cur_pos = 7'd108;
        step();
        check("fin_hold_winner", winner, 1);

`ifdef FINISH_TIMEOUT_EN
        // Entry edge began FINISHED cycle 1; two more cycles keep game_over high.
        step();
        check("hold_c3", game_over, 1);
        step();
        check("hold_c4", game_over, 1);
        step();
        check("timeout_menu",  is_in_menu,    1);
        check("timeout_over",  game_over,     0);
        check("timeout_preset", players_reset, 0);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            check("fin_persist", game_over, 1);
        end
        pulse_start();
        check("exit_menu",   is_in_menu,    1);
        check("exit_over",   game_over,     0);
        check("exit_preset", players_reset, 0);
`endif
        check("menu_valid",  winner_valid, 1);
        check("menu_winner", winner,       1);

        // Second race: blue and yellow tie.
        set_pos(7'd0, 7'd0, 7'd0, 7'd0);
        pulse_start();
        check("r2_preset", players_reset, 1);
        check("r2_valid",  winner_valid,  0);
        step();
        blue_cur_pos   = 7'd108;
        yellow_cur_pos = 7'd108;
        step();
        check("tie_over",   game_over,    1);
        check("tie_winner", winner,       2);
        check("tie_valid",  winner_valid, 1);
        pulse_start();
        check("r2_exit_menu", is_in_menu, 1);

        // Mid-race asynchronous reset during the first RACING cycle.
        set_pos(7'd0, 7'd0, 7'd0, 7'd0);
        pulse_start();
        check("r3_preset", players_reset, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_menu",   is_in_menu,    1);
        check("mid_rst_preset", players_reset, 0);
        check("mid_rst_winner", winner,        0);
        check("mid_rst_over",   game_over,     0);
        check("mid_rst_valid",  winner_valid,  0);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_menu", is_in_menu, 1);

        // Restart; every player finishes together, green wins on priority.
        pulse_start();
        check("r4_preset", players_reset, 1);
        check("r4_menu",   is_in_menu,    0);
        step();
        set_pos(7'd108, 7'd108, 7'd108, 7'd108);
        step();
        check("all_over",   game_over,    1);
        check("all_winner", winner,       0);
        check("all_valid",  winner_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/race_finish_controller.md
# race_finish_controller

Sequential game-flow controller that owns the menu/race/finish lifecycle of the LED race. It produces `is_in_menu`, which feeds the game-started check, and detects the end of a race. At race end it latches the first player to reach the finish position and holds the result for the end screen. It sits between the button/player-position logic and the screen manager.

## Interface
- `MAX_POS`, default 109: track length in LEDs; the finish position is `MAX_POS-1`.
- `HOLD_CYCLES`, default 50_000_000: number of FINISHED cycles before automatic return to menu (used only with the timeout feature).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_pulse`  in  1  one-cycle start/confirm request, already debounced upstream.
- `green_cur_pos`, `red_cur_pos`, `blue_cur_pos`, `yellow_cur_pos`  in  `$clog2(MAX_POS)` each  player positions.
- `is_in_menu`  out  1  high while in MENU.
- `game_over`  out  1  high while in FINISHED.
- `winner`  out  2  latched winner id.
- `winner_valid`  out  1  high while `winner` is meaningful.
- `players_reset`  out  1  one-cycle pulse telling the position counters to clear.

## Operation
- States: MENU, RACING, FINISHED. All outputs are registered.
- Reset values:
  - State is MENU.
  - `is_in_menu`=1.
  - `game_over`=0, `winner`=0, `winner_valid`=0, `players_reset`=0.
  - Arm flag = 0.
- MENU:
  - `start_pulse` moves the block to RACING on the next edge.
  - `players_reset` pulses for exactly one cycle, coinciding with the first RACING cycle.
  - `winner_valid` clears.
- RACING:
  - Finish detect for a player: `pos >= MAX_POS-1`.
  - Detection is masked in the first RACING cycle (arm flag clear), so stale positions cannot end the race before `players_reset` takes effect. The arm flag sets on the second RACING cycle.
  - `start_pulse` is ignored.
  - When any armed player is finished, go to FINISHED on the next edge, latch `winner`, and set `winner_valid`.
- Simultaneous finishers use fixed priority: green(0) > red(1) > blue(2) > yellow(3).
- FINISHED:
  - `winner` and `winner_valid` hold; position inputs are ignored.
  - `start_pulse` returns the block to MENU on the next edge. `winner_valid` stays high until MENU is exited again, so the menu can show the last winner.
- `rst` asserted in any state forces the reset values immediately (asynchronously). The hold counter clears.

## Timing
- Finish detect to `game_over`=1: 1 cycle.
- `start_pulse` (MENU) to `is_in_menu`=0 and `players_reset`=1: 1 cycle.
- `start_pulse` (FINISHED) to `is_in_menu`=1: 1 cycle.
- Hold counter:
  - Width is `$clog2(HOLD_CYCLES+1)`.
  - It counts only in FINISHED and is cleared on entry to FINISHED.
  - Terminal count is `HOLD_CYCLES-1`.
- If `start_pulse` and the terminal count coincide, the result is a single transition to MENU and no extra `players_reset`.

## Configuration
- `FINISH_TIMEOUT_EN` defined:
  - FINISHED returns to MENU automatically after exactly `HOLD_CYCLES` cycles in FINISHED, or earlier on `start_pulse`.
- `FINISH_TIMEOUT_EN` undefined:
  - No hold counter is synthesized.
  - FINISHED persists until `start_pulse` or `rst`.
  - `HOLD_CYCLES` is unused.

## Structure
- Shared package `race_pkg`:
  - State encoding: MENU=2'd0, RACING=2'd1, FINISHED=2'd2.
  - Player ids: GREEN=2'd0, RED=2'd1, BLUE=2'd2, YELLOW=2'd3.
- Sub-module `finish_hold_timer`:
  - Contains the clear/enable down-counter that produces a terminal-count pulse.
  - Instantiated only under `FINISH_TIMEOUT_EN`.
- Priority winner encoder stays inline.

## Test plan
- Reset release:
  - After reset: `is_in_menu`=1, `game_over`=0, `winner_valid`=0.
  - All positions at 108 with no start: block stays in MENU.
- Start with all positions at 108:
  - `start_pulse` -> `players_reset`=1 for 1 cycle.
  - No finish in the masked first RACING cycle.
  - Positions then drop to 0 and the block stays in RACING.
- Single finisher:
  - red_cur_pos 107 -> 108 -> next cycle: `game_over`=1, `winner`=1, `winner_valid`=1.
- Simultaneous finishers:
  - blue and yellow reach 108 in the same cycle -> `winner`=2.
- Exit from FINISHED:
  - With macro and `HOLD_CYCLES`=4: MENU after exactly 4 FINISHED cycles.
  - Without macro: stays FINISHED for 100 cycles, then `start_pulse` -> MENU 1 cycle later.
- Mid-race reset:
  - `rst` pulse mid-race -> outputs take reset values immediately.
  - Next `start_pulse` restarts normally.
